// File: rtl/tag_anc_pkg.sv
// Shared definitions for the tag receive scheduler:
// FSM state encodings, settings-bus addresses and CTRL bit positions.
package tag_anc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SEARCH = 3'd2,
        S_TRACK  = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } sched_state_e;

    localparam logic [7:0] ADDR_CTRL    = 8'd0;
    localparam logic [7:0] ADDR_SCALE   = 8'd1;
    localparam logic [7:0] ADDR_NOISE   = 8'd2;
    localparam logic [7:0] ADDR_NFRAMES = 8'd3;
    localparam logic [7:0] ADDR_TIMEOUT = 8'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLR   = 2;

    localparam logic [1:0] RX_INIT     = 2'b00;
    localparam logic [1:0] RX_LOC_SYNC = 2'b01;
    localparam logic [1:0] RX_START    = 2'b10;
    localparam logic [1:0] RX_LOC_RX   = 2'b11;

endpackage

// File: rtl/tag_rx_sched_regs.sv
// Settings-bus decode: CTRL strobes (combinational, one cycle)
// and shadow registers applied by the scheduler at ARM.
module tag_rx_sched_regs
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NFRM_WIDTH = 16,
    parameter int TMO_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    output logic                  start,
    output logic                  abort,
    output logic                  clr_err,
    output logic [DATA_WIDTH-1:0] sh_scale,
    output logic [31:0]           sh_noise,
    output logic [NFRM_WIDTH-1:0] sh_nframes,
    output logic [TMO_WIDTH-1:0]  sh_timeout
);

    logic [DATA_WIDTH-1:0] scale_q, scale_d;
    logic [31:0]           noise_q, noise_d;
    logic [NFRM_WIDTH-1:0] nframes_q, nframes_d;
    logic [TMO_WIDTH-1:0]  timeout_q, timeout_d;
    logic                  ctrl_wr;

    // Address decode: strobes and next shadow values
    always_comb begin
        scale_d   = scale_q;
        noise_d   = noise_q;
        nframes_d = nframes_q;
        timeout_d = timeout_q;
        ctrl_wr   = 1'b0;
        if (set_stb) begin
            unique case (set_addr)
                ADDR_CTRL:    ctrl_wr   = 1'b1;
                ADDR_SCALE:   scale_d   = set_data[DATA_WIDTH-1:0];
                ADDR_NOISE:   noise_d   = set_data;
                ADDR_NFRAMES: nframes_d = set_data[NFRM_WIDTH-1:0];
                ADDR_TIMEOUT: timeout_d = set_data[TMO_WIDTH-1:0];
                default:      ;
            endcase
        end
        start   = ctrl_wr & set_data[CTRL_START];
        abort   = ctrl_wr & set_data[CTRL_ABORT];
        clr_err = ctrl_wr & set_data[CTRL_CLR];
    end

    // Shadow register bank
    always_ff @(posedge clk) begin
        if (reset) begin
            scale_q   <= DATA_WIDTH'(1);
            noise_q   <= '0;
            nframes_q <= NFRM_WIDTH'(1);
            timeout_q <= '0;
        end else begin
            scale_q   <= scale_d;
            noise_q   <= noise_d;
            nframes_q <= nframes_d;
            timeout_q <= timeout_d;
        end
    end

    assign sh_scale   = scale_q;
    assign sh_noise   = noise_q;
    assign sh_nframes = nframes_q;
    assign sh_timeout = timeout_q;

endmodule

// File: rtl/tag_rx_sched.sv
// Receive scheduler: arms the receive controller, tracks frames,
// enforces inter-frame gaps and a peak-search timeout.
module tag_rx_sched
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NFRM_WIDTH = 16,
    parameter int TMO_WIDTH  = 32,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [1:0]            rx_state,
    output logic                  run_rx,
    output logic [DATA_WIDTH-1:0] scale_val,
    output logic [31:0]           noise_thres,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [NFRM_WIDTH-1:0] frame_count
);

    localparam logic [7:0] GAP_LOAD =
        (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 2) : 8'd0;

    logic                  start, abort, clr_err;
    logic [DATA_WIDTH-1:0] sh_scale;
    logic [31:0]           sh_noise;
    logic [NFRM_WIDTH-1:0] sh_nframes;
    logic [TMO_WIDTH-1:0]  sh_timeout;

    sched_state_e          state_q, state_d;
    logic                  run_q, run_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  seen_q, seen_d;
    logic [7:0]            gap_q, gap_d;
    logic [NFRM_WIDTH-1:0] fc_q, fc_d, fc_inc;
    logic [TMO_WIDTH-1:0]  tmo_q, tmo_d, tmo_nxt;
    logic [DATA_WIDTH-1:0] scale_q, scale_d;
    logic [31:0]           noise_q, noise_d;
    logic [NFRM_WIDTH-1:0] nfr_q, nfr_d;
    logic [TMO_WIDTH-1:0]  tlim_q, tlim_d;
    logic                  tmo_hit;

    tag_rx_sched_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .NFRM_WIDTH (NFRM_WIDTH),
        .TMO_WIDTH  (TMO_WIDTH)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .start      (start),
        .abort      (abort),
        .clr_err    (clr_err),
        .sh_scale   (sh_scale),
        .sh_noise   (sh_noise),
        .sh_nframes (sh_nframes),
        .sh_timeout (sh_timeout)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        err_d   = err_q;
        seen_d  = seen_q;
        gap_d   = gap_q;
        fc_d    = fc_q;
        tmo_d   = tmo_q;
        scale_d = scale_q;
        noise_d = noise_q;
        nfr_d   = nfr_q;
        tlim_d  = tlim_q;
        tmo_hit = 1'b0;
        tmo_nxt = tmo_q + TMO_WIDTH'(1);
        fc_inc  = (fc_q == '1) ? fc_q : fc_q + NFRM_WIDTH'(1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    fc_d    = '0;
                end
            end
            S_ARM: begin
                scale_d = sh_scale;
                noise_d = sh_noise;
                nfr_d   = sh_nframes;
                tlim_d  = sh_timeout;
                run_d   = 1'b1;
                tmo_d   = '0;
                seen_d  = 1'b0;
                state_d = S_SEARCH;
            end
            S_SEARCH: begin
                tmo_d = tmo_nxt;
                if (rx_state == RX_LOC_SYNC) begin
                    state_d = S_TRACK;
                end else if (tlim_q != '0 && tmo_nxt == tlim_q) begin
                    tmo_hit = 1'b1;
                    run_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_TRACK: begin
                if (rx_state == RX_LOC_RX) seen_d = 1'b1;
                if (rx_state == RX_INIT && seen_q) begin
                    fc_d  = fc_inc;
                    run_d = 1'b0;
                    if (nfr_q != '0 && fc_inc == nfr_q) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES <= 1) begin
                        state_d = S_ARM;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = S_ARM;
                else               gap_d   = gap_q - 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides the state move but keeps any frame count update
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            run_d   = 1'b0;
        end
        if (clr_err) err_d = 1'b0;
        if (tmo_hit) err_d = 1'b1;
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            gap_q   <= '0;
            fc_q    <= '0;
            tmo_q   <= '0;
            scale_q <= DATA_WIDTH'(1);
            noise_q <= '0;
            nfr_q   <= NFRM_WIDTH'(1);
            tlim_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            gap_q   <= gap_d;
            fc_q    <= fc_d;
            tmo_q   <= tmo_d;
            scale_q <= scale_d;
            noise_q <= noise_d;
            nfr_q   <= nfr_d;
            tlim_q  <= tlim_d;
        end
    end

    assign run_rx      = run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign frame_count = fc_q;
    assign scale_val   = scale_q;
    assign noise_thres = noise_q;

endmodule

// File: tb/tb_tag_rx_sched.sv
// Directed bench for tag_rx_sched: single frame, continuous run,
// timeout, shadowing, abort and spurious-INIT cases.
module tb_tag_rx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [1:0]  rx_state;
    logic        run_rx;
    logic [15:0] scale_val;
    logic [31:0] noise_thres;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] frame_count;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;

    tag_rx_sched dut (
        .clk         (clk),
        .reset       (reset),
        .set_stb     (set_stb),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .rx_state    (rx_state),
        .run_rx      (run_rx),
        .scale_val   (scale_val),
        .noise_thres (noise_thres),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Count done pulses over the whole run
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
    endtask

    // One frame: sync, receive, then back to INIT
    task automatic frame(input int ns, input int nr);
        rx_state = 2'b01;
        tick(ns);
        rx_state = 2'b11;
        tick(nr);
        rx_state = 2'b00;
        tick();
    endtask

    int d0;
    int low;
    int hi;

    initial begin
        reset    = 1'b1;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        rx_state = 2'b00;
        tick(2);
        reset = 1'b0;
        tick();
        chk("rst_run",   run_rx,      0);
        chk("rst_busy",  busy,        0);
        chk("rst_done",  done,        0);
        chk("rst_err",   timeout_err, 0);
        chk("rst_fc",    frame_count, 0);
        chk("rst_scale", scale_val,   1);
        chk("rst_noise", noise_thres, 0);

        // Single frame, NFRAMES=1
        wr(8'd2, 32'h0000_1234);
        wr(8'd3, 32'd1);
        d0 = done_cnt;
        wr(8'd0, 32'd1);
        chk("t1_run_n1", run_rx, 0);
        chk("t1_busy",   busy,   1);
        tick();
        chk("t1_run_n2", run_rx,      1);
        chk("t1_noise",  noise_thres, 32'h1234);
        rx_state = 2'b01;
        tick(100);
        rx_state = 2'b11;
        tick(50);
        chk("t1_run_trk", run_rx, 1);
        rx_state = 2'b00;
        tick();
        chk("t1_run_off", run_rx,      0);
        chk("t1_done",    done,        1);
        chk("t1_fc",      frame_count, 1);
        tick();
        chk("t1_done_1c", done, 0);
        chk("t1_idle",    busy, 0);
        tick();
        chk("t1_npulse",  done_cnt - d0, 1);

        // Continuous run, NFRAMES=0, three frames
        wr(8'd3, 32'd0);
        d0 = done_cnt;
        wr(8'd0, 32'd1);
        tick();
        for (int f = 0; f < 3; f++) begin
            frame(5, 5);
            low = 0;
            while (run_rx == 1'b0 && low < 50) begin
                low++;
                tick();
            end
            chk($sformatf("t2_gap%0d", f), low, 8);
        end
        chk("t2_fc", frame_count, 3);
        chk("t2_busy", busy, 1);
        wr(8'd0, 32'd2);
        tick();
        chk("t2_abort_run", run_rx,        0);
        chk("t2_fc_hold",   frame_count,   3);
        chk("t2_no_done",   done_cnt - d0, 0);

        // Timeout of 1000 cycles with rx_state stuck at INIT
        wr(8'd3, 32'd1);
        wr(8'd4, 32'd1000);
        rx_state = 2'b00;
        wr(8'd0, 32'd1);
        tick();
        hi = 0;
        while (run_rx == 1'b1 && hi < 2000) begin
            hi++;
            tick();
        end
        chk("t3_run_len", hi,          1000);
        chk("t3_err",     timeout_err, 1);
        chk("t3_busy",    busy,        0);
        wr(8'd0, 32'd4);
        chk("t3_clr",     timeout_err, 0);
        wr(8'd4, 32'd0);

        // Shadowing: SCALE written during TRACK, NFRAMES=2
        wr(8'd3, 32'd2);
        d0 = done_cnt;
        wr(8'd0, 32'd1);
        tick();
        rx_state = 2'b01;
        tick(3);
        wr(8'd1, 32'h4000);
        tick(2);
        chk("t4_scale_hold", scale_val, 1);
        rx_state = 2'b11;
        tick(3);
        rx_state = 2'b00;
        tick();
        chk("t4_scale_gap", scale_val, 1);
        low = 0;
        while (run_rx == 1'b0 && low < 50) begin
            low++;
            tick();
        end
        chk("t4_scale_new", scale_val, 16'h4000);
        frame(3, 3);
        chk("t4_fc",   frame_count, 2);
        chk("t4_done", done,        1);
        tick(2);
        chk("t4_npulse", done_cnt - d0, 1);

        // Abort during TRACK
        wr(8'd3, 32'd1);
        d0 = done_cnt;
        wr(8'd0, 32'd1);
        tick();
        rx_state = 2'b01;
        tick(4);
        rx_state = 2'b11;
        tick(2);
        wr(8'd0, 32'd2);
        chk("t5_run",  run_rx,      0);
        chk("t5_busy", busy,        0);
        chk("t5_done", done,        0);
        chk("t5_fc",   frame_count, 0);

        // Abort in the same cycle as a frame completion
        rx_state = 2'b00;
        wr(8'd0, 32'd1);
        tick();
        rx_state = 2'b01;
        tick(2);
        rx_state = 2'b11;
        tick(2);
        rx_state = 2'b00;
        wr(8'd0, 32'd2);
        chk("t7_fc",   frame_count, 1);
        chk("t7_busy", busy,        0);
        chk("t7_run",  run_rx,      0);
        tick(2);
        chk("t7_no_done", done_cnt - d0, 0);

        // Spurious INIT in TRACK, then reset mid-TRACK
        wr(8'd0, 32'd1);
        tick();
        rx_state = 2'b01;
        tick(3);
        rx_state = 2'b00;
        tick(3);
        chk("t6_run",  run_rx,      1);
        chk("t6_busy", busy,        1);
        chk("t6_fc",   frame_count, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_run",   run_rx,    0);
        chk("t6_rst_busy",  busy,      0);
        chk("t6_rst_scale", scale_val, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tag_rx_sched.md
TAG_RX_SCHED -- requirements
Module: tag_rx_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of scale_val.
REQ-002 Parameter NFRM_WIDTH, default 16, width of frame target and frame_count.
REQ-003 Parameter TMO_WIDTH, default 32, width of the peak-search timeout counter.
REQ-004 Parameter GAP_CYCLES, default 8, minimum cycles run_rx is held low between frames; legal range 1 to 255.
REQ-005 clk input 1: clock; all logic is on the rising edge.
REQ-006 reset input 1: synchronous, active-high reset.
REQ-007 set_stb, set_addr, set_data: input, widths 1/8/32; settings-bus write, qualified by set_stb.
REQ-008 rx_state input 2: receive-controller state; 00 INIT, 01 LOC_SYNC, 10 RX_START, 11 LOC_RX.
REQ-009 run_rx output 1: enable to the receive controller.
REQ-010 scale_val output DATA_WIDTH: live input scaling.
REQ-011 noise_thres output 32: live detector threshold.
REQ-012 busy, done, timeout_err: outputs, 1 bit each.
REQ-013 frame_count output NFRM_WIDTH: completed frames in the current run.

Function
REQ-014 Register map: 0 CTRL (bit0 start, bit1 abort, bit2 clr_err; all self-clearing strobes); 1 SCALE [DATA_WIDTH-1:0]; 2 NOISE [31:0]; 3 NFRAMES [NFRM_WIDTH-1:0]; 4 TIMEOUT [TMO_WIDTH-1:0]. Other addresses are ignored.
REQ-015 SCALE, NOISE, NFRAMES and TIMEOUT writes land in shadow registers in any state. Shadows are copied to the live outputs and counters only on entry to ARM.
REQ-016 States: IDLE, ARM, SEARCH, TRACK, GAP, DONE.
REQ-017 IDLE: start -> ARM; frame_count <= 0. start is ignored in all other states.
REQ-018 ARM (1 cycle): copy shadows; run_rx <= 1; clear the timeout counter -> SEARCH.
REQ-019 SEARCH: the timeout counter increments each cycle.
REQ-020 SEARCH, rx_state==01 -> TRACK.
REQ-021 SEARCH, counter==TIMEOUT with TIMEOUT!=0 -> timeout_err <= 1 (sticky); run_rx <= 0 -> IDLE.
REQ-022 SEARCH: TIMEOUT==0 disables the timeout.
REQ-023 TRACK sets a seen_rx flag when rx_state==11.
REQ-024 TRACK: when rx_state==00 with seen_rx set, the frame is complete: frame_count++ (saturating); run_rx <= 0.
REQ-025 After a complete frame: if NFRAMES!=0 and the new count==NFRAMES -> DONE; otherwise -> GAP.
REQ-026 TRACK: rx_state==00 without seen_rx does not complete a frame.
REQ-027 GAP: hold run_rx low for exactly GAP_CYCLES cycles, then -> ARM. Shadows are re-applied at that ARM.
REQ-028 DONE: done is high for 1 cycle -> IDLE.
REQ-029 abort in any state other than IDLE: run_rx <= 0 next cycle; -> IDLE; done is not asserted; frame_count holds.
REQ-030 If abort and a frame completion occur in the same cycle, abort wins and frame_count still increments.
REQ-031 clr_err clears timeout_err. If clr_err and a timeout occur in the same cycle, the timeout wins.
REQ-032 busy = (state != IDLE), registered.
REQ-033 Latency: a start write at cycle N gives run_rx high at N+2.
REQ-034 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-035 On reset: state IDLE; run_rx, busy, done, timeout_err = 0; frame_count = 0; live and shadow SCALE = 1; NOISE = 0; NFRAMES = 1; TIMEOUT = 0.
REQ-036 Reset asserted mid-run deasserts run_rx on the next cycle.

Structure
REQ-037 State encodings, register addresses and CTRL bit positions SHALL live in shared package tag_anc_pkg.
REQ-038 The settings-bus decode and shadow registers SHALL be a single sub-module, tag_rx_sched_regs.

Verification
REQ-039 Single frame: NFRAMES=1, start; drive rx_state 00->01(100 cycles)->11(50)->00. Required: run_rx high 2 cycles after start; run_rx low 1 cycle after the return to 00; done pulses once; frame_count=1.
REQ-040 Continuous run: NFRAMES=0, 3 frames. Required: run_rx low exactly 8 cycles between frames; frame_count=3; done never asserted.
REQ-041 Timeout: TIMEOUT=1000, rx_state held at 00. Required: timeout_err=1 and run_rx=0 at 1000 cycles after SEARCH entry; clr_err returns timeout_err to 0.
REQ-042 Shadowing: write SCALE=0x4000 during TRACK. Required: scale_val is unchanged until the next ARM, then equals 0x4000.
REQ-043 Abort during TRACK. Required: run_rx=0 next cycle; busy=0; done=0; frame_count is unchanged.
REQ-044 Spurious 00: rx_state 01->00 without passing through 11 in TRACK. Required: no frame count, state stays TRACK; reset mid-TRACK gives run_rx=0 next cycle.
